// File: rtl/dm_block_copy_pkg.sv
// Shared sizes and FSM encoding for the data-memory block-copy master.
package dm_block_copy_pkg;

  localparam int DM_ASIZE = 8;
  localparam int DM_DSIZE = 16;
  localparam int DM_LSIZE = DM_ASIZE + 1;

  // The data-memory bench relies on this exact 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/dm_block_copy_if.sv
// Control and memory-port bundle for the block-copy master.
// The master modport is the copy engine. The slave modport is the controller and memory side.
interface dm_block_copy_if
  import dm_block_copy_pkg::*;
#(
  parameter int ASIZE = DM_ASIZE,
  parameter int DSIZE = DM_DSIZE,
  parameter int LSIZE = DM_LSIZE
) ();

  logic             start;
  logic [ASIZE-1:0] src;
  logic [ASIZE-1:0] dst;
  logic [LSIZE-1:0] len;
  logic             busy;
  logic             done;
  logic [LSIZE-1:0] words_done;
  logic             mem_ren;
  logic             mem_wen;
  logic [ASIZE-1:0] mem_addr;
  logic [DSIZE-1:0] mem_wdata;
  logic [DSIZE-1:0] mem_rdata;

  modport master (
    input  start, src, dst, len, mem_rdata,
    output busy, done, words_done, mem_ren, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    output start, src, dst, len, mem_rdata,
    input  busy, done, words_done, mem_ren, mem_wen, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dm_block_copy.sv
// Block-copy master for the single-port data memory.
// The block copies len words from src to dst in ascending order, one read and then one write per word.
// The registered outputs follow the FSM state one cycle later. For that reason the
// memory sees the read of a word in the cycle after RD and the write of that word in the cycle after WR.
module dm_block_copy
  import dm_block_copy_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  dm_block_copy_if.master bus
);

  state_t                state_q, state_d;
  logic [DM_ASIZE-1:0]   src_q, src_d;
  logic [DM_ASIZE-1:0]   dst_q, dst_d;
  logic [DM_LSIZE-1:0]   len_q, len_d;
  logic [DM_LSIZE-1:0]   i_q, i_d;
  logic [DM_LSIZE-1:0]   words_done_q, words_done_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mem_ren_q, mem_ren_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [DM_ASIZE-1:0]   mem_addr_q, mem_addr_d;

  // Next-state logic, and the output values to register at the next edge.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    i_d          = i_q;
    words_done_d = words_done_q;
    busy_d       = (state_q == RD) || (state_q == WR);
    done_d       = (state_q == FIN);
    mem_ren_d    = (state_q == RD);
    mem_wen_d    = (state_q == WR);
    mem_addr_d   = mem_addr_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_d        = bus.src;
          dst_d        = bus.dst;
          len_d        = bus.len;
          i_d          = '0;
          words_done_d = '0;
          state_d      = (bus.len == '0) ? FIN : RD;
        end
      end
      RD: begin
        mem_addr_d = src_q + i_q[DM_ASIZE-1:0];
        state_d    = WR;
      end
      WR: begin
        mem_addr_d   = dst_q + i_q[DM_ASIZE-1:0];
        i_d          = i_q + DM_LSIZE'(1);
        words_done_d = words_done_q + DM_LSIZE'(1);
        state_d      = ((i_q + DM_LSIZE'(1)) == len_q) ? FIN : RD;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. A reset aborts any copy that is in progress, and no done pulse follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      i_q          <= '0;
      words_done_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      i_q          <= i_d;
      words_done_q <= words_done_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_ren_q    <= mem_ren_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Write data comes straight from the memory's own read register.
  // The write cycle is the cycle in which that register holds the word, so no extra buffering is needed.
  assign bus.mem_wdata  = mem_wen_q ? bus.mem_rdata : '0;
  assign bus.mem_ren    = mem_ren_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.words_done = words_done_q;

endmodule

// File: tb/tb_dm_block_copy.sv
// Self-checking bench for dm_block_copy.
// The bench pairs the block with a memory that has a 1-cycle read latency, preloaded with 0xA000+addr.
module tb_dm_block_copy;
  import dm_block_copy_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  logic [15:0] rdata_q;
  logic [15:0] mem    [256];
  logic [15:0] refMem [256];

  int compared = 0;
  int mismatched = 0;
  int overlapViolations = 0;

  typedef struct {
    int doneAt;
    int busyCnt;
    int doneCnt;
    int renCnt;
    int wenCnt;
    int wdStart;
    int wdEnd;
  } obs_t;

  dm_block_copy_if bus ();

  dm_block_copy dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Data-memory model: registered read, write on the clock edge
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 256; a++) mem[a] <= 16'hA000 + 16'(a);
    end else if (bus.mem_wen) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_ren) rdata_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  // Single-port rule: read and write are never requested in the same cycle
  always @(negedge clk) begin
    if (bus.mem_ren && bus.mem_wen) overlapViolations++;
  end

  // Reference model: the whole copy done word by word in ascending order, modulo 256
  task automatic model_preload();
    for (int a = 0; a < 256; a++) refMem[a] = 16'hA000 + 16'(a);
  endtask

  task automatic model_copy(input int s, input int d, input int l);
    for (int k = 0; k < l; k++) refMem[(d + k) % 256] = refMem[(s + k) % 256];
  endtask

  function automatic int mem_diffs(output int first);
    int bad = 0;
    first = -1;
    for (int a = 0; a < 256; a++) begin
      if (mem[a] !== refMem[a]) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    return bad;
  endfunction

  task automatic do_preload();
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
    model_preload();
  endtask

  // Issues one start and then watches a fixed window of 2*l+6 cycles. Cycle c=1 is the first cycle after the accepting edge.
  // When c equals injectAt, a second start with different operands is presented.
  task automatic run_copy(input int s, input int d, input int l,
                          input int injectAt, input int injectSrc, output obs_t o);
    o = '{doneAt: -1, busyCnt: 0, doneCnt: 0, renCnt: 0, wenCnt: 0, wdStart: -1, wdEnd: -1};
    @(negedge clk);
    bus.start = 1'b1;
    bus.src   = 8'(s);
    bus.dst   = 8'(d);
    bus.len   = 9'(l);
    for (int c = 1; c <= 2 * l + 6; c++) begin
      @(negedge clk);
      if (bus.busy)    o.busyCnt++;
      if (bus.mem_ren) o.renCnt++;
      if (bus.mem_wen) o.wenCnt++;
      if (bus.done) begin
        o.doneCnt++;
        if (o.doneAt < 0) o.doneAt = c;
      end
      if (c == 1) o.wdStart = int'(bus.words_done);
      if (c == injectAt) begin
        bus.start = 1'b1;
        bus.src   = 8'(injectSrc);
        bus.dst   = ~8'(d);
        bus.len   = 9'(l + 1);
      end else begin
        bus.start = 1'b0;
        bus.src   = 8'($urandom);
        bus.dst   = 8'($urandom);
        bus.len   = 9'($urandom);
      end
    end
    o.wdEnd = int'(bus.words_done);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if ({bus.busy, bus.done, bus.mem_ren, bus.mem_wen} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: busy/done/ren/wen=%b want 0000",
               {bus.busy, bus.done, bus.mem_ren, bus.mem_wen});
    end
    compared++;
    if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL reset_bus: addr=0x%02h wdata=0x%04h want 0", bus.mem_addr, bus.mem_wdata);
    end
    compared++;
    if (bus.words_done !== 9'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_words_done: got %0d want 0", bus.words_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    obs_t o;
    int first, bad;
    run_copy(8'h10, 8'h80, 4, 0, 0, o);
    model_copy(8'h10, 8'h80, 4);
    compared++;
    if (o.doneAt !== 10) begin
      mismatched++; $display("[TB] FAIL basic_done_at: got %0d want 10", o.doneAt);
    end
    compared++;
    if (o.busyCnt !== 8) begin
      mismatched++; $display("[TB] FAIL basic_busy_cycles: got %0d want 8", o.busyCnt);
    end
    compared++;
    if (o.doneCnt !== 1) begin
      mismatched++; $display("[TB] FAIL basic_done_pulses: got %0d want 1", o.doneCnt);
    end
    compared++;
    if (o.wdEnd !== 4) begin
      mismatched++; $display("[TB] FAIL basic_words_done: got %0d want 4", o.wdEnd);
    end
    bad = mem_diffs(first);
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("[TB] FAIL basic_mem: %0d words differ, first 0x%02h got 0x%04h want 0x%04h",
               bad, first, mem[first], refMem[first]);
    end
  endtask

  task automatic test_len_zero();
    obs_t o;
    int first, bad;
    run_copy(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 0, 0, o);
    compared++;
    if (o.doneAt !== 2 || o.doneCnt !== 1) begin
      mismatched++;
      $display("[TB] FAIL len0_done: at %0d count %0d want at 2 count 1", o.doneAt, o.doneCnt);
    end
    compared++;
    if (o.renCnt !== 0 || o.wenCnt !== 0 || o.busyCnt !== 0) begin
      mismatched++;
      $display("[TB] FAIL len0_no_access: ren %0d wen %0d busy %0d want 0 0 0",
               o.renCnt, o.wenCnt, o.busyCnt);
    end
    compared++;
    if (o.wdStart !== 0 || o.wdEnd !== 0) begin
      mismatched++;
      $display("[TB] FAIL len0_words_done: start %0d end %0d want 0 0", o.wdStart, o.wdEnd);
    end
    bad = mem_diffs(first);
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("[TB] FAIL len0_mem: %0d words differ, first 0x%02h got 0x%04h want 0x%04h",
               bad, first, mem[first], refMem[first]);
    end
  endtask

  task automatic test_wrap();
    obs_t o;
    int first, bad;
    run_copy(8'hFE, 8'h02, 4, 0, 0, o);
    model_copy(8'hFE, 8'h02, 4);
    compared++;
    if (o.doneAt !== 10 || o.renCnt !== 4 || o.wenCnt !== 4) begin
      mismatched++;
      $display("[TB] FAIL wrap_timing: done %0d ren %0d wen %0d want 10 4 4",
               o.doneAt, o.renCnt, o.wenCnt);
    end
    bad = mem_diffs(first);
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("[TB] FAIL wrap_mem: %0d words differ, first 0x%02h got 0x%04h want 0x%04h",
               bad, first, mem[first], refMem[first]);
    end
  endtask

  // Start during busy at c=3, and start during FIN at c=2l+1. The block must ignore both.
  task automatic test_start_ignored();
    obs_t o;
    int first, bad, s, d, l;
    for (int pass = 0; pass < 2; pass++) begin
      s = int'($urandom_range(0, 255));
      d = (s + 100) % 256;
      l = int'($urandom_range(3, 12));
      run_copy(s, d, l, (pass == 0) ? 3 : 2 * l + 1, (s + 50) % 256, o);
      model_copy(s, d, l);
      compared++;
      if (o.doneCnt !== 1 || o.doneAt !== 2 * l + 2) begin
        mismatched++;
        $display("[TB] FAIL ignore_start_done[%0d]: count %0d at %0d want 1 at %0d",
                 pass, o.doneCnt, o.doneAt, 2 * l + 2);
      end
      compared++;
      if (o.busyCnt !== 2 * l || o.wdEnd !== l) begin
        mismatched++;
        $display("[TB] FAIL ignore_start_busy[%0d]: busy %0d words %0d want %0d %0d",
                 pass, o.busyCnt, o.wdEnd, 2 * l, l);
      end
      bad = mem_diffs(first);
      compared++;
      if (bad !== 0) begin
        mismatched++;
        $display("[TB] FAIL ignore_start_mem[%0d]: %0d words differ, first 0x%02h got 0x%04h want 0x%04h",
                 pass, bad, first, mem[first], refMem[first]);
      end
    end
  endtask

  // A reset while the third WR state is active. Only the first two words are written.
  task automatic test_reset_mid_copy();
    obs_t o;
    int first, bad, s, d, l, extra;
    s = int'($urandom_range(0, 255));
    d = (s + 128) % 256;
    @(negedge clk);
    bus.start = 1'b1; bus.src = 8'(s); bus.dst = 8'(d); bus.len = 9'd8;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if ({bus.busy, bus.done, bus.mem_ren, bus.mem_wen} !== 4'b0 || bus.words_done !== 9'd0) begin
      mismatched++;
      $display("[TB] FAIL abort_outputs: busy/done/ren/wen=%b words=%0d want 0000 0",
               {bus.busy, bus.done, bus.mem_ren, bus.mem_wen}, bus.words_done);
    end
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done || bus.mem_ren || bus.mem_wen || bus.busy) extra++;
    end
    compared++;
    if (extra !== 0) begin
      mismatched++;
      $display("[TB] FAIL abort_quiet: %0d active cycles after reset want 0", extra);
    end
    model_copy(s, d, 2);
    bad = mem_diffs(first);
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("[TB] FAIL abort_mem: %0d words differ, first 0x%02h got 0x%04h want 0x%04h",
               bad, first, mem[first], refMem[first]);
    end
    l = int'($urandom_range(1, 10));
    s = int'($urandom_range(0, 255));
    d = int'($urandom_range(0, 255));
    run_copy(s, d, l, 0, 0, o);
    model_copy(s, d, l);
    bad = mem_diffs(first);
    compared++;
    if (o.doneAt !== 2 * l + 2 || o.wdEnd !== l || bad !== 0) begin
      mismatched++;
      $display("[TB] FAIL abort_restart: done %0d words %0d diffs %0d want %0d %0d 0",
               o.doneAt, o.wdEnd, bad, 2 * l + 2, l);
    end
  endtask

  task automatic test_overlap();
    obs_t o;
    int first, bad;
    run_copy(8'h20, 8'h21, 3, 0, 0, o);
    model_copy(8'h20, 8'h21, 3);
    compared++;
    if (mem[8'h21] !== 16'hA020 || mem[8'h22] !== 16'hA020 || mem[8'h23] !== 16'hA020) begin
      mismatched++;
      $display("[TB] FAIL overlap_words: 0x%04h 0x%04h 0x%04h want A020 A020 A020",
               mem[8'h21], mem[8'h22], mem[8'h23]);
    end
    bad = mem_diffs(first);
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("[TB] FAIL overlap_mem: %0d words differ, first 0x%02h got 0x%04h want 0x%04h",
               bad, first, mem[first], refMem[first]);
    end
  endtask

  // Random copies, plus one full 256-word copy. Each copy is checked against the ascending-copy model.
  task automatic test_random();
    obs_t o;
    int first, bad, s, d, l;
    for (int n = 0; n < 7; n++) begin
      s = int'($urandom_range(0, 255));
      d = int'($urandom_range(0, 255));
      l = (n == 6) ? 256 : int'($urandom_range(1, 24));
      run_copy(s, d, l, 0, 0, o);
      model_copy(s, d, l);
      compared++;
      if (o.doneAt !== 2 * l + 2 || o.doneCnt !== 1 || o.busyCnt !== 2 * l) begin
        mismatched++;
        $display("[TB] FAIL random_timing[%0d]: done %0d count %0d busy %0d want %0d 1 %0d",
                 n, o.doneAt, o.doneCnt, o.busyCnt, 2 * l + 2, 2 * l);
      end
      compared++;
      if (o.wdStart !== 0 || o.wdEnd !== l) begin
        mismatched++;
        $display("[TB] FAIL random_words_done[%0d]: start %0d end %0d want 0 %0d",
                 n, o.wdStart, o.wdEnd, l);
      end
      bad = mem_diffs(first);
      compared++;
      if (bad !== 0) begin
        mismatched++;
        $display("[TB] FAIL random_mem[%0d]: %0d words differ, first 0x%02h got 0x%04h want 0x%04h",
                 n, bad, first, mem[first], refMem[first]);
      end
    end
  endtask

  task automatic test_no_ren_wen_overlap();
    compared++;
    if (overlapViolations !== 0) begin
      mismatched++;
      $display("[TB] FAIL ren_wen_exclusive: %0d cycles with both high want 0", overlapViolations);
    end
  endtask

  initial begin
    preload   = 1'b0;
    bus.start = 1'b0;
    bus.src   = '0;
    bus.dst   = '0;
    bus.len   = '0;
    test_reset();
    do_preload();
    test_basic();
    test_len_zero();
    test_wrap();
    test_start_ignored();
    test_reset_mid_copy();
    test_overlap();
    test_random();
    test_no_ren_wen_overlap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
